// File: rtl/seven_seg_reader.sv
// seven_seg_reader: snoops a multiplexed, active-low seven-segment display bus
// and reconstructs the hex nibble shown on each digit.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   seg[6:0]    segments {a,b,c,d,e,f,g}, active-low (0 = lit)
//   an[D-1:0]   digit anodes, active-low; bit i low selects digit i
//   value       decoded nibbles, digit i at [4i+3:4i]
//   digit_ok    bit i set when the last commit of digit i was a known pattern
//   frame_valid one-cycle pulse when every digit has committed since the last pulse
//   err         one-cycle pulse when a commit sees an unrecognised pattern
module seven_seg_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  frame_valid,
    output logic                  err
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned SMP_W = DIGITS + SEG_W;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t state, state_d;

    logic [SMP_W-1:0]    smp;
    logic [SMP_W-1:0]    cand;
    logic [CNT_W-1:0]    cnt;
    logic [DIGITS-1:0]   seen;

    logic [DIGITS-1:0]   smp_an;
    logic [SEG_W-1:0]    smp_seg;
    logic                strobe_c;
    logic [IDX_W-1:0]    idx_c;
    logic                same_c;
    logic                commit_c;
    logic [4:0]          dec_c;

    logic [4*DIGITS-1:0] value_d;
    logic [DIGITS-1:0]   digit_ok_d;
    logic [DIGITS-1:0]   seen_d;
    logic                frame_c;

    assign smp_an  = smp[SMP_W-1:SEG_W];
    assign smp_seg = smp[SEG_W-1:0];
    assign same_c  = (smp == cand);

    // Segment pattern to {recognised, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        unique case (s)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0001100: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b0110001: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    assign dec_c = decode(smp_seg);

    // Strobe is valid only with exactly one anode low; idx_c is that digit
    always_comb begin
        int unsigned zeros;
        zeros = 0;
        idx_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!smp_an[i]) begin
                zeros = zeros + 1;
                idx_c = IDX_W'(i);
            end
        end
        strobe_c = (zeros == 1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and commit decision
    always_comb begin
        state_d  = state;
        commit_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (strobe_c) state_d = TRACK;
            end
            TRACK: begin
                if (!strobe_c) begin
                    state_d = IDLE;
                end else if (same_c && (cnt == CNT_W'(STABLE_CYCLES - 1))) begin
                    commit_c = 1'b1;
                    state_d  = HELD;
                end
            end
            HELD: begin
                if (!same_c) state_d = strobe_c ? TRACK : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next output/frame values for a commit of digit idx_c
    always_comb begin
        value_d    = value;
        digit_ok_d = digit_ok;
        seen_d     = seen;
        frame_c    = 1'b0;
        if (commit_c) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_c == IDX_W'(i)) begin
                    if (dec_c[4]) value_d[4*i +: 4] = dec_c[3:0];
                    digit_ok_d[i] = dec_c[4];
                    seen_d[i]     = 1'b1;
                end
            end
            // Completing the frame clears seen on the same edge
            if (&seen_d) begin
                frame_c = 1'b1;
                seen_d  = '0;
            end
        end
    end

    // Input sampling, candidate tracking and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            smp         <= '1;
            cand        <= '1;
            cnt         <= '0;
            seen        <= '0;
            value       <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            smp <= {an, seg};
            if (!same_c) begin
                cand <= smp;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
            seen        <= seen_d;
            value       <= value_d;
            digit_ok    <= digit_ok_d;
            frame_valid <= frame_c;
            err         <= commit_c && !dec_c[4];
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader (DIGITS=4, STABLE_CYCLES=4).
module tb_seven_seg_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_ok;
    logic        frame_valid;
    logic        err;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int fv_base;
    int err_base;

    seven_seg_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with digit 0 showing '3'
        reset = 1'b1;
        an    = 4'b1110;
        seg   = 7'b0000110;
        tick();
        tick();
        check("rst_value", 32'(value), 32'h0);
        check("rst_ok", 32'(digit_ok), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        repeat (4) tick();
        check("rst_early_value", 32'(value), 32'h0);
        check("rst_early_ok", 32'(digit_ok), 32'h0);
        tick();
        check("rst_commit_value", 32'(value[3:0]), 32'h3);
        check("rst_commit_ok", 32'(digit_ok), 32'h1);
        drive(4'b1111, 7'b1111111, 2);

        // Full frame 1 C A 2
        fv_base  = fv_cnt;
        err_base = err_cnt;
        drive(4'b1110, 7'b0010010, 6);
        drive(4'b1101, 7'b0001000, 6);
        drive(4'b1011, 7'b0110001, 6);
        an  = 4'b0111;
        seg = 7'b1001111;
        repeat (4) tick();
        check("frame_fv_before", 32'(frame_valid), 32'h0);
        tick();
        check("frame_fv_pulse", 32'(frame_valid), 32'h1);
        check("frame_value", 32'(value), 32'h1CA2);
        check("frame_ok", 32'(digit_ok), 32'hF);
        tick();
        check("frame_fv_after", 32'(frame_valid), 32'h0);
        check("frame_fv_count", 32'(fv_cnt - fv_base), 32'h1);
        check("frame_err_count", 32'(err_cnt - err_base), 32'h0);
        drive(4'b1111, 7'b1111111, 2);

        // Glitch: 3 samples only
        fv_base  = fv_cnt;
        err_base = err_cnt;
        drive(4'b1110, 7'b0000000, 3);
        drive(4'b1111, 7'b1111111, 4);
        check("glitch_value", 32'(value), 32'h1CA2);
        check("glitch_ok", 32'(digit_ok), 32'hF);
        check("glitch_seen", 32'(dut.seen), 32'h0);
        check("glitch_pulses", 32'((fv_cnt - fv_base) + (err_cnt - err_base)), 32'h0);

        // Unrecognised pattern on digit 2, then '5'
        err_base = err_cnt;
        an  = 4'b1011;
        seg = 7'b1111110;
        repeat (4) tick();
        check("bad_err_before", 32'(err), 32'h0);
        tick();
        check("bad_err_pulse", 32'(err), 32'h1);
        check("bad_ok", 32'(digit_ok), 32'hB);
        check("bad_value", 32'(value), 32'h1CA2);
        tick();
        check("bad_err_after", 32'(err), 32'h0);
        check("bad_err_count", 32'(err_cnt - err_base), 32'h1);
        drive(4'b1011, 7'b0100100, 6);
        check("fix_value", 32'(value), 32'h15A2);
        check("fix_ok", 32'(digit_ok), 32'hF);
        check("fix_seen", 32'(dut.seen), 32'h4);

        // Two anodes low: never a strobe
        fv_base  = fv_cnt;
        err_base = err_cnt;
        drive(4'b1100, 7'b0001100, 20);
        check("multi_value", 32'(value), 32'h15A2);
        check("multi_seen", 32'(dut.seen), 32'h4);
        // Long hold commits once
        drive(4'b1101, 7'b0001100, 20);
        check("hold_value", 32'(value), 32'h1592);
        check("hold_ok", 32'(digit_ok), 32'hF);
        check("hold_seen", 32'(dut.seen), 32'h6);
        check("hold_pulses", 32'((fv_cnt - fv_base) + (err_cnt - err_base)), 32'h0);
        drive(4'b1111, 7'b1111111, 2);

        // Reset in the middle of a frame
        fv_base = fv_cnt;
        drive(4'b1110, 7'b0000000, 6);
        drive(4'b1101, 7'b0001111, 6);
        drive(4'b1011, 7'b0110000, 6);
        check("mid_value_pre", 32'(value), 32'h1E78);
        reset = 1'b1;
        drive(4'b1111, 7'b1111111, 2);
        reset = 1'b0;
        drive(4'b1111, 7'b1111111, 2);
        drive(4'b0111, 7'b0111000, 6);
        check("mid_value", 32'(value), 32'hF000);
        check("mid_ok", 32'(digit_ok), 32'h8);
        check("mid_fv_count", 32'(fv_cnt - fv_base), 32'h0);
        check("mid_seen", 32'(dut.seen), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
